// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pin-bank arbiter.
package uio_arb_pkg;

   // Width of the uio pin bank.
   localparam int UIO_W = 8;

   // Arbiter state.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TURN = 2'd1,
      ST_OWN  = 2'd2
   } arb_state_e;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req searching upward from ptr+1 with wrap.
module rr_pick
   import uio_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   // One spare bit so ptr+1+k can be reduced modulo NUM_REQ by a single subtract.
   localparam int SW = IDX_W + 1;

   logic [SW-1:0] base;
   logic [SW-1:0] j;

   // Walk candidates farthest-first so the nearest requester after ptr wins.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      base    = SW'(ptr_i) + SW'(1);
      if (base >= SW'(NUM_REQ)) base = base - SW'(NUM_REQ);
      j       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = base + SW'(k);
         if (j >= SW'(NUM_REQ)) j = j - SW'(NUM_REQ);
         if (req_i[j[IDX_W-1:0]]) begin
            idx_o   = j[IDX_W-1:0];
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uio_share_arbiter.sv
// Round-robin owner of the shared uio pin bank with turnaround gap and bounded hold.
module uio_share_arbiter
   import uio_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int MAX_HOLD   = 4,
   parameter int TURNAROUND = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ-1:0]       drive,
   input  logic [UIO_W*NUM_REQ-1:0] wdata,
   input  logic [UIO_W*NUM_REQ-1:0] wmask,
   input  logic [UIO_W-1:0]         uio_in,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [UIO_W-1:0]         rdata,
   output logic [UIO_W-1:0]         uio_out,
   output logic [UIO_W-1:0]         uio_oe,
   output logic                     busy
);

   localparam int IDX_W = clog2_min1(NUM_REQ);
   localparam int TC_W  = clog2_min1(TURNAROUND);
   localparam int HC_W  = clog2_min1(MAX_HOLD);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [TC_W-1:0]  turn_cnt_q, turn_cnt_d;
   logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [UIO_W-1:0] rdata_q;

   logic [NUM_REQ-1:0][UIO_W-1:0] wdata_a, wmask_a;
   logic [NUM_REQ-1:0] own_oh;
   logic [IDX_W-1:0]   pick_ptr, pick_idx;
   logic               pick_vld, others;

   // Split the flat per-requester buses into indexable slices.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign wdata_a[g] = wdata[g*UIO_W +: UIO_W];
      assign wmask_a[g] = wmask[g*UIO_W +: UIO_W];
   end

   assign own_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
   assign others = |(req & ~own_oh);

   // Leaving OWN, the search starts after the current owner (the new ptr);
   // from IDLE it starts after the last owner.
   assign pick_ptr = (state_q == ST_OWN) ? owner_q : ptr_q;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (req),
      .ptr_i   (pick_ptr),
      .idx_o   (pick_idx),
      .valid_o (pick_vld)
   );

   // Next-state logic for state, owner, ptr and the two counters.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      turn_cnt_d = turn_cnt_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               owner_d    = pick_idx;
               turn_cnt_d = '0;
               state_d    = ST_TURN;
            end
         end
         ST_TURN: begin
            if (turn_cnt_q < TC_W'(TURNAROUND - 1)) begin
               turn_cnt_d = turn_cnt_q + 1'b1;
            end else if (req[owner_q]) begin
               hold_cnt_d = '0;
               state_d    = ST_OWN;
            end else begin
               // Pick withdrew during the gap: no grant, ptr untouched.
               state_d = ST_IDLE;
            end
         end
         ST_OWN: begin
            if (!req[owner_q]) begin
               ptr_d = owner_q;
               if (pick_vld) begin
                  owner_d    = pick_idx;
                  turn_cnt_d = '0;
                  state_d    = ST_TURN;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if ((hold_cnt_q == HC_W'(MAX_HOLD - 1)) && others) begin
               ptr_d      = owner_q;
               owner_d    = pick_idx;
               turn_cnt_d = '0;
               state_d    = ST_TURN;
            end else if (hold_cnt_q != HC_W'(MAX_HOLD - 1)) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; ptr resets to the last requester so requester 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         ptr_q      <= IDX_W'(NUM_REQ - 1);
         turn_cnt_q <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         turn_cnt_q <= turn_cnt_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Pin sample for readers, taken only while someone owns the bank.
   always_ff @(posedge clk) begin
      if (rst)                    rdata_q <= '0;
      else if (state_q == ST_OWN) rdata_q <= uio_in;
   end

   // Pin mux: only the owner reaches the pins; everything else keeps them as inputs.
   always_comb begin
      gnt     = '0;
      uio_out = '0;
      uio_oe  = '0;
      if (state_q == ST_OWN) begin
         gnt     = own_oh;
         uio_out = wdata_a[owner_q];
         uio_oe  = drive[owner_q] ? wmask_a[owner_q] : '0;
      end
   end

   assign rdata = rdata_q;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uio_share_arbiter.sv
// Directed bench for uio_share_arbiter at default parameters.
module tb_uio_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, drive, gnt;
   logic [31:0] wdata, wmask;
   logic [7:0]  uio_in, rdata, uio_out, uio_oe;
   logic        busy;

   int errors = 0;
   int checks = 0;

   uio_share_arbiter #(.NUM_REQ(4), .MAX_HOLD(4), .TURNAROUND(1)) dut (
      .clk(clk), .rst(rst), .req(req), .drive(drive), .wdata(wdata), .wmask(wmask),
      .uio_in(uio_in), .gnt(gnt), .rdata(rdata), .uio_out(uio_out), .uio_oe(uio_oe),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [7:0] wd1;
      logic [7:0] uin;
      logic [3:0] gnt_e;
      logic [7:0] out_e;
      logic [7:0] oe_e;
      logic [7:0] rd_e;
      logic       busy_e;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic r, input logic [3:0] rq, input logic [7:0] wd1,
                      input logic [7:0] uin, input logic [3:0] g, input logic [7:0] o,
                      input logic [7:0] oe, input logic [7:0] rd, input logic b);
      vec_t v;
      v.rst = r; v.req = rq; v.wd1 = wd1; v.uin = uin;
      v.gnt_e = g; v.out_e = o; v.oe_e = oe; v.rd_e = rd; v.busy_e = b;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      req    = '0;
      drive  = 4'b1011;
      wdata  = {8'hD3, 8'h62, 8'hA5, 8'h17};
      wmask  = {8'h0F, 8'hFF, 8'hF0, 8'hC3};
      uio_in = '0;

      // rst req   wd1    uin    gnt    out    oe     rdata  busy
      add(1, 4'b0000, 8'hA5, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 0); // 0 reset
      add(0, 4'b0001, 8'hA5, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 1); // 1 TURN
      add(0, 4'b0001, 8'hA5, 8'h00, 4'b0001, 8'h17, 8'hC3, 8'h00, 1); // 2 OWN r0
      add(0, 4'b0001, 8'hA5, 8'h5A, 4'b0001, 8'h17, 8'hC3, 8'h5A, 1); // 3 sample
      add(1, 4'b0001, 8'hA5, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 0); // 4 mid-OWN reset
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 1); // 5 TURN
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0001, 8'h17, 8'hC3, 8'h00, 1); // 6 r0 first
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0001, 8'h17, 8'hC3, 8'h00, 1);
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0001, 8'h17, 8'hC3, 8'h00, 1);
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0001, 8'h17, 8'hC3, 8'h00, 1); // 9 4th OWN
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 1); // 10 gap
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0010, 8'hA5, 8'hF0, 8'h00, 1); // 11 r1
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0010, 8'hA5, 8'hF0, 8'h00, 1);
      add(0, 4'b1111, 8'hC6, 8'h00, 4'b0010, 8'hC6, 8'hF0, 8'h00, 1); // 13 data change
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0010, 8'hA5, 8'hF0, 8'h00, 1);
      add(0, 4'b1111, 8'hA5, 8'h00, 4'b0000, 8'h00, 8'h00, 8'h00, 1); // 15 gap
      add(0, 4'b1111, 8'hA5, 8'h3C, 4'b0100, 8'h62, 8'h00, 8'h00, 1); // 16 r2 reads
      add(0, 4'b1111, 8'hA5, 8'h3C, 4'b0100, 8'h62, 8'h00, 8'h3C, 1);
      add(0, 4'b1111, 8'hA5, 8'h3C, 4'b0100, 8'h62, 8'h00, 8'h3C, 1);
      add(0, 4'b1111, 8'hA5, 8'h3C, 4'b0100, 8'h62, 8'h00, 8'h3C, 1);
      add(0, 4'b1111, 8'hA5, 8'h3C, 4'b0000, 8'h00, 8'h00, 8'h3C, 1); // 20 gap
      add(0, 4'b1111, 8'hA5, 8'h99, 4'b1000, 8'hD3, 8'h0F, 8'h3C, 1); // 21 rdata held
      add(0, 4'b1111, 8'hA5, 8'h99, 4'b1000, 8'hD3, 8'h0F, 8'h99, 1);
      add(0, 4'b1111, 8'hA5, 8'h99, 4'b1000, 8'hD3, 8'h0F, 8'h99, 1);
      add(0, 4'b1111, 8'hA5, 8'h99, 4'b1000, 8'hD3, 8'h0F, 8'h99, 1);
      add(0, 4'b1111, 8'hA5, 8'h99, 4'b0000, 8'h00, 8'h00, 8'h99, 1); // 25 gap
      add(0, 4'b1111, 8'hA5, 8'h99, 4'b0001, 8'h17, 8'hC3, 8'h99, 1); // 26 wrap to r0

      foreach (vt[i]) begin
         rst    = vt[i].rst;
         req    = vt[i].req;
         uio_in = vt[i].uin;
         wdata  = {8'hD3, 8'h62, vt[i].wd1, 8'h17};
         cyc();
         chk($sformatf("row%0d gnt", i),   {4'h0, gnt},   {4'h0, vt[i].gnt_e});
         chk($sformatf("row%0d out", i),   uio_out,       vt[i].out_e);
         chk($sformatf("row%0d oe", i),    uio_oe,        vt[i].oe_e);
         chk($sformatf("row%0d rdata", i), rdata,         vt[i].rd_e);
         chk($sformatf("row%0d busy", i),  {7'h0, busy},  {7'h0, vt[i].busy_e});
      end

      // Sole requester drops: back to IDLE next cycle, re-request takes two cycles.
      rst = 1'b1; req = '0; cyc(); rst = 1'b0;
      req = 4'b0100;
      cyc(); chk("t3 turn gnt", {4'h0, gnt}, 8'h00);
      cyc(); chk("t3 own gnt", {4'h0, gnt}, 8'h04);
      cyc(); cyc();
      chk("t3 3rd own", {4'h0, gnt}, 8'h04);
      req = '0;
      cyc(); chk("t3 drop gnt", {4'h0, gnt}, 8'h00);
      chk("t3 drop busy", {7'h0, busy}, 8'h00);
      chk("t3 drop oe", uio_oe, 8'h00);
      req = 4'b0100;
      cyc(); chk("t3 re turn", {4'h0, gnt}, 8'h00);
      cyc(); chk("t3 re own", {4'h0, gnt}, 8'h04);

      // Sole owner never preempted; a newcomer after saturation preempts next edge.
      req = '0; cyc();
      req = 4'b0001;
      cyc(); cyc();
      for (int n = 1; n <= 10; n++) begin
         chk($sformatf("t5 own%0d", n), {4'h0, gnt}, 8'h01);
         if (n < 10) cyc();
      end
      req = 4'b1001;
      cyc(); chk("t5 preempt gnt", {4'h0, gnt}, 8'h00);
      chk("t5 preempt busy", {7'h0, busy}, 8'h01);
      cyc(); chk("t5 r3 gnt", {4'h0, gnt}, 8'h08);

      // Pick withdraws during TURN: no grant pulse, ptr unchanged (3).
      req = '0; cyc();
      req = 4'b0010;
      cyc(); chk("t6 turn gnt", {4'h0, gnt}, 8'h00);
      req = '0;
      cyc(); chk("t6 idle gnt", {4'h0, gnt}, 8'h00);
      chk("t6 idle busy", {7'h0, busy}, 8'h00);
      cyc(); chk("t6 no pulse", {4'h0, gnt}, 8'h00);
      req = 4'b0101;
      cyc(); cyc(); chk("t6 ptr kept", {4'h0, gnt}, 8'h01);

      // Release with others waiting: straight to TURN, no extra IDLE.
      req = 4'b0100;
      cyc(); chk("rel turn gnt", {4'h0, gnt}, 8'h00);
      chk("rel turn busy", {7'h0, busy}, 8'h01);
      chk("rel turn oe", uio_oe, 8'h00);
      cyc(); chk("rel next own", {4'h0, gnt}, 8'h04);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the bench cannot hang.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/uio_share_arbiter.md
Name: uio_share_arbiter

Overview:
Round-robin arbiter that shares the 8-bit bidirectional uio pin bank of a tt_um_* user design between NUM_REQ internal requesters.
- Grants exclusive pin ownership to one requester at a time.
- Inserts an all-inputs turnaround gap between owners and bounds hold time when others are waiting.
- Muxes the owner's drive data/enable onto uio_out/uio_oe and samples uio_in for readers.
- Sits between the user logic blocks and the top-level uio_in/uio_out/uio_oe ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_HOLD, 4, OWN cycles after which the owner is preempted if another request is pending (>=1)
TURNAROUND, 1, cycles with uio_oe=0 between owners (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  request per requester, level, held until done
drive  in  NUM_REQ  per requester, 1 = drive pins, 0 = read pins
wdata  in  8*NUM_REQ  drive data, slice i = requester i
wmask  in  8*NUM_REQ  per-bit output enable while driving, slice i
uio_in  in  8  pin input path
gnt  out  NUM_REQ  one-hot grant, high only in OWN
rdata  out  8  registered sample of uio_in
uio_out  out  8  pin output path
uio_oe  out  8  pin enable path (1 = output)
busy  out  1  high in TURN or OWN

Behaviour:
- States: IDLE, TURN, OWN. Registers: state, owner, ptr (last owner), turn_cnt, hold_cnt, rdata.
- Reset, synchronous, also mid-operation:
  - state=IDLE, ptr=NUM_REQ-1 so requester 0 wins first, counters=0, rdata=0.
  - All outputs 0 in the cycle after the reset edge.
- Pick function: first asserted req searching from (ptr+1) mod NUM_REQ upward with wrap.
- IDLE:
  - gnt=0, uio_oe=0, uio_out=0.
  - If any req: owner<=pick, turn_cnt<=0, go TURN.
- TURN:
  - gnt=0, uio_oe=0, uio_out=0.
  - Stays while turn_cnt<TURNAROUND-1, else:
    - req[owner]=1: go OWN, hold_cnt<=0.
    - req[owner]=0: go IDLE, no grant issued, ptr unchanged.
- OWN:
  - gnt[owner]=1.
  - uio_out = wdata[owner], combinational mux.
  - uio_oe = drive[owner] ? wmask[owner] : 8'h00.
  - rdata<=uio_in every OWN cycle; rdata holds its value in other states.
  - hold_cnt increments and saturates at MAX_HOLD-1.
  - Exits, evaluated at each edge:
    - req[owner]=0: release. ptr<=owner; any other req → TURN with owner<=pick using the new ptr, else → IDLE.
    - hold_cnt=MAX_HOLD-1 and another req is pending: preempt. ptr<=owner, owner<=pick, go TURN.
  - Sole requester is never preempted and holds indefinitely.
- Latency:
  - req rising in IDLE → gnt high 1+TURNAROUND cycles later (2 at defaults).
  - req falling in OWN → gnt low the next cycle.
  - Owner-to-owner gap is exactly TURNAROUND cycles with uio_oe=0.
- Simultaneous events:
  - Owner releases while others request: release path applies, with no extra IDLE cycle.
  - drive/wmask/wdata changes mid-OWN: reflected immediately on uio_out/uio_oe.
- Invariants:
  - gnt is at most one-hot.
  - uio_oe is 0 whenever gnt==0.
  - busy = (state != IDLE).

Decomposition:
- Shared package uio_arb_pkg holds:
  - state enum type (IDLE/TURN/OWN)
  - IDX_W = $clog2(NUM_REQ) width helper
  - UIO_W = 8 constant
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: idx, valid.
  - Reused for both the IDLE and OWN-exit picks.

Test Plan:
1. Reset, then req=0001 → gnt=0000 for 2 cycles, then gnt=0001, busy=1. Assert rst mid-OWN → gnt=0, uio_oe=0, busy=0 next cycle; then req=1111 → requester 0 granted first.
2. req=1111 held, defaults → grant order 0,1,2,3,0. Each OWN lasts exactly 4 cycles, separated by 1 cycle of gnt=0, uio_oe=00.
3. req[2] alone for 3 OWN cycles, then dropped → gnt=0 next cycle, state IDLE, uio_oe=00. Re-assert req[2] → gnt[2] after 2 cycles.
4. Owner 1: drive=1, wdata=A5, wmask=F0 → uio_out=A5, uio_oe=F0. Owner 2: drive=0, uio_in=3C → uio_oe=00, rdata=3C one cycle after first OWN cycle, and rdata holds 3C after release.
5. req[0] alone for 10 OWN cycles → no preemption. Raise req[3] at OWN cycle 10 → gnt[0] drops next edge, gnt[3] rises one TURN cycle later.
6. req[1] drops during TURN → no gnt pulse, return to IDLE. Next pick still starts at ptr+1 (ptr unchanged).
